// File: rtl/event_pkg.sv
// Shared types and default constants for the event responder and its delay timer.
package event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_DELAY   = 1;
    localparam int unsigned DEF_MAX_TXN = 3;
    localparam int unsigned CNT_W       = 8;

endpackage

// File: rtl/event_delay_timer.sv
// Loadable down-counter: load_i presets LOAD_VAL, tick_i decrements, flags report zero and last count.
module event_delay_timer
    import event_pkg::*;
#(
    parameter int unsigned LOAD_VAL = DEF_DELAY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic tick_i,
    output logic zero_o,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LOAD_C = CNT_W'(LOAD_VAL);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_C;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    // Last count means the next tick brings the counter to zero.
    assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/event_responder.sv
// Request/acknowledge responder: accepts events, acknowledges after DELAY cycles,
// queues one request while busy and stops after MAX_TXN acknowledges.
module event_responder
    import event_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned DELAY   = DEF_DELAY,
    parameter int unsigned MAX_TXN = DEF_MAX_TXN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] value_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_TXN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_TXN - 1);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  value_q, value_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               tmr_load;
    logic               tmr_tick;
    logic               tmr_zero;
    logic               tmr_last;

    event_delay_timer #(
        .LOAD_VAL (DELAY)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .tick_i (tmr_tick),
        .zero_o (tmr_zero),
        .last_o (tmr_last)
    );

    assign accept = ((state_q == IDLE) || (state_q == ACK)) && !done_q && (req_i || pending_q);

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        pending_d = pending_q;
        txn_d     = txn_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) state_d = WAIT;
            end
            WAIT: begin
                tmr_tick = 1'b1;
                if (tmr_last || tmr_zero) state_d = ACK;
                // Once done, late requests are discarded without flagging overrun.
                if (req_i && !done_q) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
            end
            ACK: begin
                if (txn_q != MAX_C) txn_d = txn_q + CNT_W'(1);
                if (txn_q == LAST_C) done_d = 1'b1;
                state_d = accept ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A served pending request leaves room for a simultaneous new one.
        if (accept) begin
            value_d   = value_q + DATA_W'(1);
            tmr_load  = 1'b1;
            pending_d = pending_q && req_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            value_q   <= '0;
            pending_q <= 1'b0;
            txn_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            pending_q <= pending_d;
            txn_q     <= txn_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign ack_o     = (state_q == ACK);
    assign busy_o    = (state_q != IDLE);
    assign value_o   = value_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_event_responder.sv
// Bench for event_responder: four parameterisations checked against a timestamp-based reference model.
module tb_event_responder;

    typedef struct {
        logic   rst_n;
        logic   req;
        logic   ack;
        logic   busy;
        longint val;
        logic   done;
        logic   ovr;
    } vec_t;

    logic        clk;
    logic [3:0]  rstn;
    logic [3:0]  req;
    logic [3:0]  ack_w, busy_w, done_w, ovr_w;
    logic [31:0] val_a;
    logic [7:0]  val_b;
    logic [1:0]  val_c;
    logic [3:0]  val_r;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model state per instance: last acceptance edge and bookkeeping.
    bit     m_valid[4];
    int     m_k[4];
    bit     m_pend[4];
    longint m_val[4];
    int     m_acks[4];
    bit     m_done[4];
    bit     m_ovr[4];

    event_responder #(.DATA_W(32), .DELAY(1), .MAX_TXN(3)) dut_a (
        .clk(clk), .rst_n(rstn[0]), .req_i(req[0]), .ack_o(ack_w[0]), .value_o(val_a),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .overrun_o(ovr_w[0]));
    event_responder #(.DATA_W(8), .DELAY(4), .MAX_TXN(3)) dut_b (
        .clk(clk), .rst_n(rstn[1]), .req_i(req[1]), .ack_o(ack_w[1]), .value_o(val_b),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .overrun_o(ovr_w[1]));
    event_responder #(.DATA_W(2), .DELAY(2), .MAX_TXN(5)) dut_c (
        .clk(clk), .rst_n(rstn[2]), .req_i(req[2]), .ack_o(ack_w[2]), .value_o(val_c),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .overrun_o(ovr_w[2]));
    event_responder #(.DATA_W(4), .DELAY(3), .MAX_TXN(40)) dut_r (
        .clk(clk), .rst_n(rstn[3]), .req_i(req[3]), .ack_o(ack_w[3]), .value_o(val_r),
        .busy_o(busy_w[3]), .done_o(done_w[3]), .overrun_o(ovr_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_delay(int i);
        case (i)
            0: return 1;
            1: return 4;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int p_max(int i);
        case (i)
            0: return 3;
            1: return 3;
            2: return 5;
            default: return 40;
        endcase
    endfunction

    function automatic longint p_mask(int i);
        case (i)
            0: return 64'hFFFF_FFFF;
            1: return 64'hFF;
            2: return 64'h3;
            default: return 64'hF;
        endcase
    endfunction

    function automatic longint get_val(int i);
        case (i)
            0: return longint'(val_a);
            1: return longint'(val_b);
            2: return longint'(val_c);
            default: return longint'(val_r);
        endcase
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Model: a transaction accepted at edge k is in flight through edge k+DELAY,
    // acknowledges in the cycle after edge k+DELAY and retires at edge k+DELAY+1.
    task automatic model_step(input int i);
        bit in_wait, ack_end, new_done;
        if (!rstn[i]) begin
            m_valid[i] = 0; m_k[i] = 0; m_pend[i] = 0; m_val[i] = 0;
            m_acks[i] = 0; m_done[i] = 0; m_ovr[i] = 0;
            return;
        end
        in_wait  = m_valid[i] && (edge_n > m_k[i]) && (edge_n <= m_k[i] + p_delay(i));
        ack_end  = m_valid[i] && (edge_n == m_k[i] + p_delay(i) + 1);
        new_done = m_done[i];
        if (ack_end) begin
            if (m_acks[i] < p_max(i)) m_acks[i]++;
            if (m_acks[i] == p_max(i)) new_done = 1;
        end
        if (!in_wait && !m_done[i] && (req[i] || m_pend[i])) begin
            m_val[i]   = (m_val[i] + 1) & p_mask(i);
            m_pend[i]  = m_pend[i] && req[i];
            m_k[i]     = edge_n;
            m_valid[i] = 1;
        end else if (in_wait && !m_done[i] && req[i]) begin
            if (m_pend[i]) m_ovr[i] = 1;
            else           m_pend[i] = 1;
        end
        m_done[i] = new_done;
    endtask

    task automatic chk_model(input int i);
        bit e_busy, e_ack;
        e_busy = m_valid[i] && (edge_n <= m_k[i] + p_delay(i));
        e_ack  = m_valid[i] && (edge_n == m_k[i] + p_delay(i));
        cmp($sformatf("model_ack[%0d]", i),  longint'(ack_w[i]),  longint'(e_ack));
        cmp($sformatf("model_busy[%0d]", i), longint'(busy_w[i]), longint'(e_busy));
        cmp($sformatf("model_val[%0d]", i),  get_val(i),          m_val[i]);
        cmp($sformatf("model_done[%0d]", i), longint'(done_w[i]), longint'(m_done[i]));
        cmp($sformatf("model_ovr[%0d]", i),  longint'(ovr_w[i]),  longint'(m_ovr[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 4; i++) model_step(i);
        #1;
        for (int i = 0; i < 4; i++) chk_model(i);
    endtask

    task automatic wait_ack(input int i, input int lim, input string nm);
        bit seen;
        seen = 0;
        for (int n = 0; n < lim; n++) begin
            tick();
            if (ack_w[i]) begin
                seen = 1;
                break;
            end
        end
        cmp(nm, longint'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t   tbl[12];
        int     acks;
        int     t1, t2;
        longint seq[5];
        longint exp_seq[5];

        rstn = '0;
        req  = '0;

        // Single request, then three spaced transactions up to done (DELAY=1, MAX_TXN=3).
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};

        #1;
        for (int v = 0; v < 12; v++) begin
            rstn[0] = tbl[v].rst_n;
            req[0]  = tbl[v].req;
            tick();
            cmp($sformatf("tbl%0d_ack", v),  longint'(ack_w[0]),  longint'(tbl[v].ack));
            cmp($sformatf("tbl%0d_busy", v), longint'(busy_w[0]), longint'(tbl[v].busy));
            cmp($sformatf("tbl%0d_val", v),  longint'(val_a),     tbl[v].val);
            cmp($sformatf("tbl%0d_done", v), longint'(done_w[0]), longint'(tbl[v].done));
            cmp($sformatf("tbl%0d_ovr", v),  longint'(ovr_w[0]),  longint'(tbl[v].ovr));
        end
        req[0] = 0;

        // Pending and overrun with DELAY=4: requests on three consecutive edges.
        rstn[1] = 1;
        acks = 0;
        for (int n = 0; n < 3; n++) begin
            req[1] = 1;
            tick();
            if (ack_w[1]) acks++;
        end
        req[1] = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (ack_w[1]) acks++;
        end
        cmp("pend_ack_count", longint'(acks), 2);
        cmp("pend_value", longint'(val_b), 2);
        cmp("pend_overrun", longint'(ovr_w[1]), 1);

        // Back-to-back: request during the ACK cycle is accepted at that edge.
        rstn[1] = 0;
        tick();
        rstn[1] = 1;
        req[1] = 1;
        tick();
        req[1] = 0;
        wait_ack(1, 10, "b2b_first_ack");
        t1 = edge_n;
        req[1] = 1;
        tick();
        req[1] = 0;
        cmp("b2b_value", longint'(val_b), 2);
        cmp("b2b_busy", longint'(busy_w[1]), 1);
        wait_ack(1, 10, "b2b_second_ack");
        t2 = edge_n;
        cmp("b2b_spacing", longint'(t2 - t1), 5);
        tick();

        // Two-bit value wrap across five transactions, ending in done.
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0; exp_seq[4] = 1;
        rstn[2] = 1;
        for (int t = 0; t < 5; t++) begin
            req[2] = 1;
            tick();
            seq[t] = longint'(val_c);
            req[2] = 0;
            wait_ack(2, 10, $sformatf("wrap_ack%0d", t));
            tick();
        end
        for (int t = 0; t < 5; t++) cmp($sformatf("wrap_seq%0d", t), seq[t], exp_seq[t]);
        cmp("wrap_done", longint'(done_w[2]), 1);

        // Reset during WAIT cancels the transaction.
        rstn[1] = 0;
        tick();
        rstn[1] = 1;
        req[1] = 1;
        tick();
        req[1] = 0;
        tick();
        rstn[1] = 0;
        tick();
        cmp("rst_ack", longint'(ack_w[1]), 0);
        cmp("rst_busy", longint'(busy_w[1]), 0);
        cmp("rst_val", longint'(val_b), 0);
        cmp("rst_done", longint'(done_w[1]), 0);
        cmp("rst_ovr", longint'(ovr_w[1]), 0);
        rstn[1] = 1;
        acks = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (ack_w[1]) acks++;
        end
        cmp("rst_no_ack", longint'(acks), 0);

        // Randomised traffic with occasional resets on the DELAY=3 instance.
        rstn[3] = 1;
        for (int n = 0; n < 2000; n++) begin
            req[3]  = ($urandom_range(0, 9) < 4);
            rstn[3] = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
